// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types and constants for the multi-lane fetch queue.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package fetch_queue_pkg;

  localparam int unsigned FQ_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int unsigned INSTR_WIDTH   = 32;

  // One fetched instruction with its branch prediction; also the lane
  // payload of the future multi-lane fetch_out interface.
  typedef struct packed {
    logic [FQ_ADDR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0]   instr;
    logic                     guesses_branch;
    logic [FQ_ADDR_WIDTH-1:0] prediction;
  } fetch_entry_t;

  // Flattened entry width for a given address width, laid out like
  // fetch_entry_t: {pc, instr, guesses_branch, prediction}.
  function automatic int unsigned entry_width(int unsigned addr_w);
    return 2 * addr_w + INSTR_WIDTH + 1;
  endfunction

endpackage

// File: rtl/fetch_lane_compact.sv
// Packs the valid lanes of a group into a dense prefix (lane order kept)
// and reports how many lanes were valid.
module fetch_lane_compact #(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 8
) (
  input  logic [LANES-1:0]             valid_i,
  input  logic [LANES*W-1:0]           data_i,
  output logic [LANES*W-1:0]           dense_o,
  output logic [$clog2(LANES+1)-1:0]   count_o
);

  // Walk lanes oldest-first; each valid lane lands in the next free slot.
  always_comb begin
    dense_o = '0;
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid_i[i]) begin
        dense_o[count_o*W +: W] = data_i[i*W +: W];
        count_o = count_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane instruction buffer between fetch and decode. Circular storage
// with head/tail pointers and an occupancy count; flushed on mispredict.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_WIDTH   = FQ_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [FETCH_WIDTH-1:0]               in_valid,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]    in_pc,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0]   in_instr,
  input  logic [FETCH_WIDTH-1:0]               in_guesses_branch,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]    in_prediction,
  output logic                                 in_ready,
  output logic [DECODE_WIDTH-1:0]              out_valid,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0]   out_pc,
  output logic [DECODE_WIDTH*INSTR_WIDTH-1:0]  out_instr,
  output logic [DECODE_WIDTH-1:0]              out_guesses_branch,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0]   out_prediction,
  input  logic [DECODE_WIDTH-1:0]              out_ready,
  input  logic                                 flush,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_WIDTH);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned FCNT_W  = $clog2(FETCH_WIDTH+1);
  localparam int unsigned DCNT_W  = $clog2(DECODE_WIDTH+1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [FETCH_WIDTH*ENTRY_W-1:0] lane_entries;
  logic [FETCH_WIDTH*ENTRY_W-1:0] dense_entries;
  logic [FCNT_W-1:0]              enq_n;
  logic                           enq_fire;
  logic [DCNT_W-1:0]              deq_n;
  logic                           deq_run;

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_pack
    assign lane_entries[gi*ENTRY_W +: ENTRY_W] = {
      in_pc[gi*ADDR_WIDTH +: ADDR_WIDTH],
      in_instr[gi*INSTR_WIDTH +: INSTR_WIDTH],
      in_guesses_branch[gi],
      in_prediction[gi*ADDR_WIDTH +: ADDR_WIDTH]
    };
  end

  fetch_lane_compact #(
    .LANES (FETCH_WIDTH),
    .W     (ENTRY_W)
  ) u_compact (
    .valid_i (in_valid),
    .data_i  (lane_entries),
    .dense_o (dense_entries),
    .count_o (enq_n)
  );

  // Room for a whole group, judged on the registered count only.
  assign in_ready  = (32'(count_q) + FETCH_WIDTH) <= DEPTH;
  assign enq_fire  = in_ready & (|in_valid) & ~flush;
  assign occupancy = count_q;

  for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
    logic [PTR_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0] rd_entry;
    assign rd_addr  = head_q + PTR_W'(gi);
    assign rd_entry = mem_q[rd_addr];
    assign out_valid[gi] = ~flush & (32'(count_q) > gi);
    assign out_pc[gi*ADDR_WIDTH +: ADDR_WIDTH]         = rd_entry[ENTRY_W-1 -: ADDR_WIDTH];
    assign out_instr[gi*INSTR_WIDTH +: INSTR_WIDTH]    = rd_entry[ADDR_WIDTH+1 +: INSTR_WIDTH];
    assign out_guesses_branch[gi]                      = rd_entry[ADDR_WIDTH];
    assign out_prediction[gi*ADDR_WIDTH +: ADDR_WIDTH] = rd_entry[ADDR_WIDTH-1:0];
  end

  // Count the leading run of consumed lanes; ready bits after a gap are ignored.
  always_comb begin
    deq_n   = '0;
    deq_run = 1'b1;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      deq_run = deq_run & out_valid[i] & out_ready[i];
      if (deq_run) deq_n = deq_n + 1'b1;
    end
  end

  // Next pointers/count; a flush empties the queue and drops this cycle's enqueue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      if (enq_fire) tail_d = tail_q + PTR_W'(enq_n);
      count_d = count_q + (enq_fire ? CNT_W'(enq_n) : CNT_W'(0)) - CNT_W'(deq_n);
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: compacted lanes are written at tail, tail+1, ... with wrap.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (FCNT_W'(k) < enq_n) begin
          mem_q[tail_q + PTR_W'(k)] <= dense_entries[k*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!n_rst)
    count_q <= CNT_W'(DEPTH));
  a_valid_prefix: assert property (@(posedge clk) disable iff (!n_rst)
    (out_valid & (out_valid + 1'b1)) == '0);
  a_ptr_consistent: assert property (@(posedge clk) disable iff (!n_rst)
    (head_q + PTR_W'(count_q)) == tail_q);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int FW = 2;
  localparam int DW = 2;
  localparam int DEPTH = 8;
  localparam int AW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic          gb;
    logic [AW-1:0] pred;
  } ent_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [FW-1:0]    in_valid = '0;
  logic [FW*AW-1:0] in_pc = '0;
  logic [FW*32-1:0] in_instr = '0;
  logic [FW-1:0]    in_guesses_branch = '0;
  logic [FW*AW-1:0] in_prediction = '0;
  logic             in_ready;
  logic [DW-1:0]    out_valid;
  logic [DW*AW-1:0] out_pc;
  logic [DW*32-1:0] out_instr;
  logic [DW-1:0]    out_guesses_branch;
  logic [DW*AW-1:0] out_prediction;
  logic [DW-1:0]    out_ready = '0;
  logic             flush = 1'b0;
  logic [3:0]       occupancy;

  ent_t model_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_guesses_branch(in_guesses_branch), .in_prediction(in_prediction),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_guesses_branch(out_guesses_branch), .out_prediction(out_prediction),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy)
  );

  task automatic set_lane(input int k, input logic [AW-1:0] pc);
    in_valid[k] = 1'b1;
    in_pc[k*AW +: AW] = pc;
    in_instr[k*32 +: 32] = $urandom;
    in_guesses_branch[k] = 1'($urandom_range(0, 1));
    in_prediction[k*AW +: AW] = $urandom;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    flush = 1'b0;
  endtask

  // Queue-level model: pop the consumed prefix, append the valid lanes in order.
  task automatic step();
    int n;
    bit stop;
    bit enq;
    ent_t e;
    n = 0;
    stop = 0;
    for (int i = 0; i < DW; i++) begin
      if (!stop && !flush && i < model_q.size() && out_ready[i]) n++;
      else stop = 1;
    end
    enq = !flush && (model_q.size() + FW <= DEPTH) && (in_valid != 0);
    if (flush) begin
      model_q.delete();
    end else begin
      for (int i = 0; i < n; i++) void'(model_q.pop_front());
      if (enq) begin
        for (int k = 0; k < FW; k++) begin
          if (in_valid[k]) begin
            e.pc = in_pc[k*AW +: AW];
            e.instr = in_instr[k*32 +: 32];
            e.gb = in_guesses_branch[k];
            e.pred = in_prediction[k*AW +: AW];
            model_q.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_out_valid got=%b want=00", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_q.delete();
    $display("test_reset: occupancy=%0d in_ready=%b", occupancy, in_ready);
  endtask

  task automatic test_basic();
    out_ready = 2'b00;
    set_lane(0, 32'h100);
    set_lane(1, 32'h104);
    step();
    clear_inputs();
    total++; if (out_valid !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b want=11", out_valid); end
    total++; if (out_pc !== {32'h104, 32'h100}) begin bad++; $display("FAIL basic_pc got=%h want=%h", out_pc, {32'h104, 32'h100}); end
    total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL basic_occ got=%0d want=2", occupancy); end
    out_ready = 2'b11;
    step();
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL basic_drain got=%0d want=0", occupancy); end
    $display("test_basic: pcs=%h", {32'h104, 32'h100});
  endtask

  task automatic test_sparse();
    out_ready = 2'b00;
    set_lane(1, 32'h208);
    in_pc[0 +: AW] = 32'hdead;
    step();
    clear_inputs();
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL sparse_valid got=%b want=01", out_valid); end
    total++; if (out_pc[0 +: AW] !== 32'h208) begin bad++; $display("FAIL sparse_pc got=%h want=208", out_pc[0 +: AW]); end
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL sparse_occ got=%0d want=1", occupancy); end
    out_ready = 2'b11;
    step();
    $display("test_sparse: lane0 pc=208 occupancy now=%0d", occupancy);
  endtask

  task automatic test_fill_full();
    out_ready = 2'b00;
    for (int g = 0; g < 4; g++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b want=1", g, in_ready); end
      set_lane(0, 32'h400 + 8 * g);
      set_lane(1, 32'h404 + 8 * g);
      step();
    end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL fill_occ got=%0d want=8", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", in_ready); end
    set_lane(0, 32'h500);
    set_lane(1, 32'h504);
    step();
    clear_inputs();
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_ignore_occ got=%0d want=8", occupancy); end
    total++; if (out_pc !== {32'h404, 32'h400}) begin bad++; $display("FAIL full_ignore_pc got=%h want=%h", out_pc, {32'h404, 32'h400}); end
    out_ready = 2'b01;
    step();
    total++; if (occupancy !== 4'd7) begin bad++; $display("FAIL part_occ got=%0d want=7", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL part_ready got=%b want=0", in_ready); end
    total++; if (out_pc[0 +: AW] !== 32'h404) begin bad++; $display("FAIL part_pc got=%h want=404", out_pc[0 +: AW]); end
    out_ready = 2'b11;
    step();
    total++; if (occupancy !== 4'd5) begin bad++; $display("FAIL part2_occ got=%0d want=5", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL part2_ready got=%b want=1", in_ready); end
    total++; if (out_pc[0 +: AW] !== 32'h40c) begin bad++; $display("FAIL part2_pc got=%h want=40c", out_pc[0 +: AW]); end
    for (int i = 0; i < 3; i++) step();
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL fill_drain got=%0d want=0", occupancy); end
    $display("test_fill_full: drained occupancy=%0d", occupancy);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] got_q[$];
    int g;
    g = 0;
    out_ready = 2'b11;
    for (int c = 0; c < 40 && (g < 20 || model_q.size() != 0); c++) begin
      clear_inputs();
      if (g < 20 && model_q.size() + FW <= DEPTH) begin
        set_lane(0, 32'h1000 + 8 * g);
        set_lane(1, 32'h1004 + 8 * g);
        g++;
      end
      for (int i = 0; i < DW; i++) if (out_valid[i]) got_q.push_back(out_pc[i*AW +: AW]);
      total++; if (occupancy > 4'd2) begin bad++; $display("FAIL wrap_occ cycle=%0d got=%0d want<=2", c, occupancy); end
      step();
    end
    clear_inputs();
    total++; if (got_q.size() != 40) begin bad++; $display("FAIL wrap_count got=%0d want=40", got_q.size()); end
    for (int k = 0; k < 40 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== 32'h1000 + 4 * k) begin bad++; $display("FAIL wrap_pc_%0d got=%h want=%h", k, got_q[k], 32'h1000 + 4 * k); end
    end
    $display("test_wrap: delivered=%0d", got_q.size());
  endtask

  task automatic test_flush();
    out_ready = 2'b00;
    set_lane(0, 32'h600); set_lane(1, 32'h604); step();
    set_lane(0, 32'h608); set_lane(1, 32'h60c); step();
    clear_inputs();
    set_lane(0, 32'h610); step();
    clear_inputs();
    total++; if (occupancy !== 4'd5) begin bad++; $display("FAIL flush_pre_occ got=%0d want=5", occupancy); end
    set_lane(0, 32'h700); set_lane(1, 32'h704);
    out_ready = 2'b11;
    flush = 1'b1;
    #1;
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b want=00", out_valid); end
    step();
    clear_inputs();
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_after_valid got=%b want=00", out_valid); end
    set_lane(0, 32'h300);
    out_ready = 2'b00;
    step();
    clear_inputs();
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL flush_new_valid got=%b want=01", out_valid); end
    total++; if (out_pc[0 +: AW] !== 32'h300) begin bad++; $display("FAIL flush_new_pc got=%h want=300", out_pc[0 +: AW]); end
    out_ready = 2'b11;
    step();
    set_lane(0, 32'h900); set_lane(1, 32'h904);
    flush = 1'b1;
    step();
    clear_inputs();
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL flush_empty_occ got=%0d want=0", occupancy); end
    $display("test_flush: post-flush pc=300 seen, occupancy=%0d", occupancy);
  endtask

  task automatic test_reset_mid();
    out_ready = 2'b00;
    set_lane(0, 32'h800); set_lane(1, 32'h804);
    step();
    clear_inputs();
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL midrst_valid got=%b want=00", out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL midrst_occ got=%0d want=0", occupancy); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    n_rst = 1'b1;
    model_q.delete();
    $display("test_reset_mid: occupancy=%0d", occupancy);
  endtask

  task automatic test_random();
    bit exp_v;
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int k = 0; k < FW; k++) if ($urandom_range(0, 2) != 0) set_lane(k, $urandom);
      out_ready = 2'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      total++; if (in_ready !== (model_q.size() + FW <= DEPTH)) begin bad++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", c, in_ready, (model_q.size() + FW <= DEPTH)); end
      total++; if (occupancy !== 4'(model_q.size())) begin bad++; $display("FAIL rnd_occ cycle=%0d got=%0d want=%0d", c, occupancy, model_q.size()); end
      for (int i = 0; i < DW; i++) begin
        exp_v = !flush && (i < model_q.size());
        total++; if (out_valid[i] !== exp_v) begin bad++; $display("FAIL rnd_valid cycle=%0d lane=%0d got=%b want=%b", c, i, out_valid[i], exp_v); end
        if (exp_v) begin
          total++;
          if (out_pc[i*AW +: AW] !== model_q[i].pc || out_instr[i*32 +: 32] !== model_q[i].instr ||
              out_guesses_branch[i] !== model_q[i].gb || out_prediction[i*AW +: AW] !== model_q[i].pred) begin
            bad++;
            $display("FAIL rnd_entry cycle=%0d lane=%0d got=%h/%h/%b/%h want=%h/%h/%b/%h", c, i,
                     out_pc[i*AW +: AW], out_instr[i*32 +: 32], out_guesses_branch[i], out_prediction[i*AW +: AW],
                     model_q[i].pc, model_q[i].instr, model_q[i].gb, model_q[i].pred);
          end
        end
      end
      step();
    end
    clear_inputs();
    $display("test_random: cycles=400 final occupancy=%0d", occupancy);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_fill_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
